// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Holds the transmitter state enum, field widths and the header-pack helper.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } tx_state_e;

  // Header byte carries the payload length in the upper six bits, port in the low two.
  function automatic logic [DATA_W-1:0] pack_header(input logic [ADDR_W-1:0] addr,
                                                    input logic [LEN_W-1:0]  len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: MAX_LEN x 8 registers with write/read pointers.
// clear resets both pointers; contents are simply overwritten by the next packet.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  wr_ptr,
  output logic [LEN_W-1:0]  rd_ptr
);

  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(MAX_LEN);

  logic [DATA_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + LEN_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && (wr_ptr < DEPTH)) mem[wr_ptr] <= wr_data;
  end

  // The pointer can sit one past the last entry once the payload is drained.
  assign rd_data = (rd_ptr < DEPTH) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Router ingress packet source: collects a payload, then sends header, payload, parity.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_parity_err to corrupt the sent parity byte.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN  = 63,
  parameter int IDLE_GAP = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] hdr_addr,
  input  logic [LEN_W-1:0]  hdr_len,
  output logic              tx_ready,
  input  logic              pld_valid,
  input  logic [DATA_W-1:0] pld_data,
  output logic              pld_ready,
  input  logic              busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic              inj_parity_err,
`endif
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_done,
  output logic              start_err,
  output tx_state_e         dbg_state
);

  localparam int GAP_W = 8;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP - 1);

  tx_state_e         state_q, state_d;
  logic              pkt_valid_d, tx_done_d, start_err_d;
  logic [DATA_W-1:0] data_out_d;
  logic              start_ok, load_start, buf_wr, buf_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] parity_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              inj_q;
  logic [DATA_W-1:0] buf_rd_data;
  logic [LEN_W-1:0]  wr_ptr, rd_ptr;

  router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (load_start),
    .wr_en   (buf_wr),
    .wr_data (pld_data),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr)
  );

  assign start_ok  = (hdr_addr != ADDR_INVALID) && (hdr_len != '0) && (hdr_len <= MAX_LEN_L);
  assign tx_ready  = (state_q == ST_IDLE);
  assign pld_ready = (state_q == ST_COLLECT);
  assign dbg_state = state_q;

  // Handshakes: a payload byte moves on an edge with pld_valid && pld_ready; a router
  // byte moves on an edge in HEADER/PAYLOAD/PARITY with busy low, otherwise it holds.
  // pkt_valid/data_out are loaded with the value the next state presents.
  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid;
    data_out_d  = data_out;
    tx_done_d   = 1'b0;
    start_err_d = 1'b0;
    load_start  = 1'b0;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            load_start = 1'b1;
            state_d    = ST_COLLECT;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (pld_valid) begin
          buf_wr = 1'b1;
          if (wr_ptr == len_q - LEN_W'(1)) begin
            state_d     = ST_HEADER;
            pkt_valid_d = 1'b1;
            data_out_d  = pack_header(addr_q, len_q);
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          state_d    = ST_PAYLOAD;
          data_out_d = buf_rd_data;
          buf_rd     = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr == len_q) begin
            state_d     = ST_PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = parity_q ^ {DATA_W{inj_q}};
          end else begin
            data_out_d = buf_rd_data;
            buf_rd     = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          tx_done_d = 1'b1;
          state_d   = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_done   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_valid <= pkt_valid_d;
      data_out  <= data_out_d;
      tx_done   <= tx_done_d;
      start_err <= start_err_d;
    end
  end

  // Parity starts from the header and folds in every collected payload byte.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q   <= '0;
      len_q    <= '0;
      parity_q <= '0;
      gap_cnt  <= '0;
    end else begin
      if (load_start) begin
        addr_q   <= hdr_addr;
        len_q    <= hdr_len;
        parity_q <= pack_header(hdr_addr, hdr_len);
      end else if (buf_wr) begin
        parity_q <= parity_q ^ pld_data;
      end
      gap_cnt <= (state_q == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

`ifdef ROUTER_TX_PARITY_INJ_EN
  always_ff @(posedge clock) begin
    if (!resetn)         inj_q <= 1'b0;
    else if (load_start) inj_q <= inj_parity_err;
  end
`else
  assign inj_q = 1'b0;
`endif

endmodule
